// File: rtl/alu_muldiv_unit.sv
// ----------------------------------------------------------------------------
// alu_muldiv_unit
//
// Iterative RISC-V M-extension multiply/divide unit. One request at a time:
// a multiply runs as radix-2 shift-add and a divide runs as radix-2 restoring
// shift-subtract. Both take XLEN CALC cycles followed by one DONE cycle.
// A divide by zero, or the signed overflow case, skips CALC and goes
// straight to DONE.
//
// Ports
//   clk_i     : clock, rising edge
//   rst_i     : synchronous active-high reset; has priority over everything
//   valid_i   : request present on funct3_i / a_i / b_i
//   ready_o   : unit idle, able to accept a request this cycle
//   funct3_i  : 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//               100 DIV, 101 DIVU, 110 REM, 111 REMU
//   a_i       : rs1 (multiplicand / dividend)
//   b_i       : rs2 (multiplier / divisor)
//   kill_i    : flush; aborts an in-flight op and blocks acceptance
//   valid_o   : one-cycle pulse, result_o holds a completed result
//   result_o  : result, held until the next completed operation
//   busy_o    : operation in flight (inverse of ready_o)
// ----------------------------------------------------------------------------
module alu_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            kill_i,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_LOAD = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t              state_q;
    logic [2:0]          op_q;
    logic                neg_res_q;   // product / quotient must be negated
    logic                neg_rem_q;   // remainder must be negated (dividend sign)
    logic [XLEN-1:0]     mcand_q;     // multiplicand magnitude, or divisor magnitude
    logic [2*XLEN-1:0]   acc_q;       // mul: {partial hi, multiplier}; div: {rem, quotient}
    logic [CW-1:0]       cnt_q;
    logic [XLEN-1:0]     result_q;
    logic                ready_q;
    logic                valid_q;
    logic                busy_q;

    assign ready_o  = ready_q;
    assign valid_o  = valid_q;
    assign busy_o   = busy_q;
    assign result_o = result_q;

    // ------------------------------------------------------------------
    // Request conditioning: which operands are signed, their magnitudes,
    // and the fast-path (no iteration) detection and result.
    // ------------------------------------------------------------------
    logic            accept;
    logic            a_signed;
    logic            b_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            b_zero;
    logic            div_ovf;
    logic            fast;
    logic [XLEN-1:0] fast_res;

    assign accept = (state_q == IDLE) && valid_i && !kill_i;

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (funct3_i)
            3'b001: begin                 // MULH
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            3'b010: begin                 // MULHSU
                a_signed = 1'b1;
            end
            3'b100, 3'b110: begin         // DIV, REM
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign a_neg = a_signed & a_i[XLEN-1];
    assign b_neg = b_signed & b_i[XLEN-1];
    assign a_mag = a_neg ? ('0 - a_i) : a_i;
    assign b_mag = b_neg ? ('0 - b_i) : b_i;

    assign b_zero  = (b_i == '0);
    assign div_ovf = !funct3_i[0] && (a_i == MOST_NEG) && (b_i == '1);
    assign fast    = funct3_i[2] && (b_zero || div_ovf);

    // Divide by zero: quotient all ones, remainder = dividend.
    // Signed overflow: quotient = dividend, remainder = 0.
    always_comb begin
        if (b_zero) begin
            fast_res = funct3_i[1] ? a_i : '1;
        end else begin
            fast_res = funct3_i[1] ? '0 : a_i;
        end
    end

    // ------------------------------------------------------------------
    // One radix-2 iteration on the accumulator.
    // ------------------------------------------------------------------
    logic [XLEN-1:0]   mul_addend;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_sh;
    logic [XLEN:0]     div_diff;
    logic              div_ok;
    logic [XLEN-1:0]   div_rem_n;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] step_next;

    // Shift-add: add multiplicand into the high half when the current
    // multiplier LSB is set, then shift the whole accumulator right,
    // keeping the carry as the new MSB.
    assign mul_addend = acc_q[0] ? mcand_q : '0;
    assign mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mul_addend};
    assign mul_next   = {mul_sum, acc_q[XLEN-1:1]};

    // Restoring divide: shift the next dividend bit into the partial
    // remainder, trial-subtract, keep the difference if it did not borrow.
    assign div_sh    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_diff  = div_sh - {1'b0, mcand_q};
    assign div_ok    = !div_diff[XLEN];
    assign div_rem_n = div_ok ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
    assign div_next  = {div_rem_n, acc_q[XLEN-2:0], div_ok};

    assign step_next = op_q[2] ? div_next : mul_next;

    // ------------------------------------------------------------------
    // Sign fix-up and result selection, taken from the accumulator value
    // produced by the final iteration so result_o is valid throughout DONE.
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] prod_f;
    logic [XLEN-1:0]   quo_f;
    logic [XLEN-1:0]   rem_f;
    logic [XLEN-1:0]   final_res;

    assign prod_f = neg_res_q ? ('0 - step_next) : step_next;
    assign quo_f  = neg_res_q ? ('0 - step_next[XLEN-1:0]) : step_next[XLEN-1:0];
    assign rem_f  = neg_rem_q ? ('0 - step_next[2*XLEN-1:XLEN])
                              : step_next[2*XLEN-1:XLEN];

    always_comb begin
        case (op_q)
            3'b000:                 final_res = prod_f[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod_f[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_res = quo_f;
            default:                final_res = rem_f;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM with registered handshake outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            op_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            mcand_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q      <= funct3_i;
                        neg_res_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        cnt_q     <= CNT_LOAD;
                        ready_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        if (funct3_i[2]) begin
                            mcand_q <= b_mag;
                            acc_q   <= {{XLEN{1'b0}}, a_mag};
                        end else begin
                            mcand_q <= a_mag;
                            acc_q   <= {{XLEN{1'b0}}, b_mag};
                        end
                        if (fast) begin
                            state_q  <= DONE;
                            result_q <= fast_res;
                            valid_q  <= 1'b1;
                        end else begin
                            state_q  <= CALC;
                        end
                    end
                end

                CALC: begin
                    if (kill_i) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q <= step_next;
                        cnt_q <= cnt_q - CW'(1);
                        if (cnt_q == '0) begin
                            state_q  <= DONE;
                            result_q <= final_res;
                            valid_q  <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    // Leaves after one cycle whether or not kill_i is set.
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
